// File: rtl/hf_mode_sequencer_pkg.sv
// Shared HF command and mode-sequencer definitions: opcodes, the OFF major
// mode and the sequencer state encoding.
package hf_mode_sequencer_pkg;

    localparam logic [3:0] FPGA_CMD_SET_CONFREG  = 4'd1;
    localparam logic [3:0] FPGA_CMD_TRACE_ENABLE = 4'd2;

    localparam logic [2:0] FPGA_MAJOR_MODE_OFF = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUIESCE = 2'd1,
        SWITCH  = 2'd2,
        SETTLE  = 2'd3
    } seq_state_t;

    // Major-mode field of a SET_CONFREG payload.
    function automatic logic [2:0] cfg_major(input logic [8:0] cfg);
        return cfg[8:6];
    endfunction

endpackage

// File: rtl/hf_seq_timer.sv
// Down-counter used for both the guard (drive-off) and settle intervals.
// done is high in the last cycle of the loaded interval.
module hf_seq_timer (
    input  logic       clk,
    input  logic       nreset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       count,
    output logic       done
);

    logic [7:0] remaining;

    // Load on state entry, count down while enabled, park at zero rather than wrap.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            remaining <= 8'd0;
        end else if (load) begin
            remaining <= load_val;
        end else if (count && (remaining != 8'd0)) begin
            remaining <= remaining - 8'd1;
        end
    end

    // A zero count also reports done so the sequencer can never stall.
    assign done = (remaining <= 8'd1);

endmodule

// File: rtl/hf_mode_sequencer.sv
// HF mode sequencer: applies ARM configuration commands to the FPGA mode mux,
// gating coil drive off for a guard interval before any major-mode change and
// holding it off for a settle interval afterwards. nreset is expected to come
// from the top-level synchroniser, so its release is already clock-aligned.
module hf_mode_sequencer
    import hf_mode_sequencer_pkg::*;
#(
    parameter int GUARD_CYCLES  = 64,
    parameter int SETTLE_CYCLES = 32
) (
    input  logic        ck_1356meg,
    input  logic        nreset,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_word,
    output logic [2:0]  major_mode,
    output logic [3:0]  minor_mode,
    output logic [1:0]  subcarrier_frequency,
    output logic        trace_enable,
    output logic        pwr_gate,
    output logic        busy,
    output logic        cmd_overwrite
);

    localparam logic [7:0] GUARD_LOAD  = 8'(GUARD_CYCLES);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    seq_state_t  state;
    logic [8:0]  target_cfg;
    logic        pend_full;
    logic [8:0]  pend_cfg;

    logic [3:0]  opcode;
    logic [8:0]  payload;
    logic        is_conf;
    logic        is_trace;
    logic        have_cfg;
    logic [8:0]  cfg;
    logic        start_switch;
    logic        enter_settle;
    logic        timer_load;
    logic [7:0]  timer_val;
    logic        timer_count;
    logic        timer_done;
    logic        unused_cmd_bits;

    assign opcode          = cmd_word[15:12];
    assign payload         = cmd_word[8:0];
    assign unused_cmd_bits = ^cmd_word[11:9];
    assign is_conf         = cmd_valid && (opcode == FPGA_CMD_SET_CONFREG);
    assign is_trace        = cmd_valid && (opcode == FPGA_CMD_TRACE_ENABLE);

    // In IDLE a pending command takes precedence over a newly arriving one.
    assign have_cfg     = pend_full || is_conf;
    assign cfg          = pend_full ? pend_cfg : payload;
    assign start_switch = (state == IDLE) && have_cfg && (cfg_major(cfg) != major_mode);
    assign enter_settle = (state == SWITCH) && (cfg_major(target_cfg) != FPGA_MAJOR_MODE_OFF);
    assign timer_load   = start_switch || enter_settle;
    assign timer_val    = start_switch ? GUARD_LOAD : SETTLE_LOAD;
    assign timer_count  = (state == QUIESCE) || (state == SETTLE);

    hf_seq_timer u_timer (
        .clk      (ck_1356meg),
        .nreset   (nreset),
        .load     (timer_load),
        .load_val (timer_val),
        .count    (timer_count),
        .done     (timer_done)
    );

    // Trace enable is independent of the transition sequence.
    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            trace_enable <= 1'b0;
        end else if (is_trace) begin
            trace_enable <= cmd_word[0];
        end
    end

    // Command payloads carry no reset; their valid flags do.
    always_ff @(posedge ck_1356meg) begin
        if (start_switch) begin
            target_cfg <= cfg;
        end
        if (is_conf && ((state != IDLE) || pend_full)) begin
            pend_cfg <= payload;
        end
    end

    // Transition sequencer with registered mode, gate and status outputs.
    always_ff @(posedge ck_1356meg or negedge nreset) begin
        if (!nreset) begin
            state                <= IDLE;
            major_mode           <= FPGA_MAJOR_MODE_OFF;
            minor_mode           <= 4'd0;
            subcarrier_frequency <= 2'd0;
            pwr_gate             <= 1'b0;
            busy                 <= 1'b0;
            cmd_overwrite        <= 1'b0;
            pend_full            <= 1'b0;
        end else begin
            cmd_overwrite <= 1'b0;
            case (state)
                IDLE: begin
                    // Slot is consumed now; a command arriving this cycle waits in it.
                    if (pend_full) begin
                        pend_full <= is_conf;
                    end
                    if (have_cfg) begin
                        if (start_switch) begin
                            state    <= QUIESCE;
                            pwr_gate <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            minor_mode           <= cfg[3:0];
                            subcarrier_frequency <= cfg[5:4];
                        end
                    end
                end
                QUIESCE: begin
                    if (timer_done) begin
                        state <= SWITCH;
                    end
                end
                SWITCH: begin
                    major_mode           <= cfg_major(target_cfg);
                    minor_mode           <= target_cfg[3:0];
                    subcarrier_frequency <= target_cfg[5:4];
                    if (enter_settle) begin
                        state <= SETTLE;
                    end else begin
                        state    <= IDLE;
                        pwr_gate <= 1'b0;
                        busy     <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (timer_done) begin
                        state    <= IDLE;
                        pwr_gate <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if ((state != IDLE) && is_conf) begin
                pend_full     <= 1'b1;
                cmd_overwrite <= pend_full;
            end
        end
    end

endmodule

// File: tb/tb_hf_mode_sequencer.sv
// Directed and randomized bench for hf_mode_sequencer with a latency-based
// reference model (elapsed cycles since a transition was accepted).
module tb_hf_mode_sequencer;

    localparam int G = 64;
    localparam int S = 32;

    logic        ck_1356meg = 1'b0;
    logic        nreset     = 1'b0;
    logic        cmd_valid  = 1'b0;
    logic [15:0] cmd_word   = 16'h0000;
    logic [2:0]  major_mode;
    logic [3:0]  minor_mode;
    logic [1:0]  subcarrier_frequency;
    logic        trace_enable;
    logic        pwr_gate;
    logic        busy;
    logic        cmd_overwrite;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int ovw_seen = 0;

    // Reference model state
    logic [2:0] m_major;
    logic [3:0] m_minor;
    logic [1:0] m_sub;
    logic       m_trace;
    logic       m_pwr;
    logic       m_ovw;
    bit         m_active;
    int         m_t;
    logic [8:0] m_tgt;
    bit         m_pend;
    logic [8:0] m_pcfg;

    logic [15:0] rw;
    int          kind;

    hf_mode_sequencer #(
        .GUARD_CYCLES  (G),
        .SETTLE_CYCLES (S)
    ) dut (
        .ck_1356meg           (ck_1356meg),
        .nreset               (nreset),
        .cmd_valid            (cmd_valid),
        .cmd_word             (cmd_word),
        .major_mode           (major_mode),
        .minor_mode           (minor_mode),
        .subcarrier_frequency (subcarrier_frequency),
        .trace_enable         (trace_enable),
        .pwr_gate             (pwr_gate),
        .busy                 (busy),
        .cmd_overwrite        (cmd_overwrite)
    );

    always #5 ck_1356meg = ~ck_1356meg;

    function automatic logic [15:0] confreg(input logic [2:0] maj, input logic [1:0] sub,
                                            input logic [3:0] mnr);
        return {4'h1, 3'b000, maj, sub, mnr};
    endfunction

    function automatic logic [15:0] trace_cmd(input logic b);
        return {4'h2, 11'd0, b};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_major  = 3'd7;
        m_minor  = 4'd0;
        m_sub    = 2'd0;
        m_trace  = 1'b0;
        m_pwr    = 1'b0;
        m_ovw    = 1'b0;
        m_active = 1'b0;
        m_t      = 0;
        m_tgt    = 9'd0;
        m_pend   = 1'b0;
        m_pcfg   = 9'd0;
    endtask

    // One clock edge of behaviour: a transition runs G guard cycles, one switch
    // cycle, then S settle cycles unless the new mode is OFF.
    task automatic model_edge(input logic v, input logic [15:0] w);
        logic       conf;
        logic [8:0] p;
        logic [8:0] cfg;
        bit         have;
        conf  = v && (w[15:12] == 4'h1);
        p     = w[8:0];
        m_ovw = 1'b0;
        if (v && (w[15:12] == 4'h2)) m_trace = w[0];
        if (m_active) begin
            if (conf) begin
                m_ovw  = m_pend;
                m_pend = 1'b1;
                m_pcfg = p;
            end
            if (m_t == G + 1) begin
                m_major = m_tgt[8:6];
                m_minor = m_tgt[3:0];
                m_sub   = m_tgt[5:4];
            end
            if (((m_tgt[8:6] == 3'd7) && (m_t == G + 1)) || (m_t == G + 1 + S)) begin
                m_active = 1'b0;
                m_pwr    = (m_tgt[8:6] != 3'd7);
            end else begin
                m_t++;
            end
        end else begin
            have = m_pend || conf;
            cfg  = m_pend ? m_pcfg : p;
            if (m_pend) begin
                m_pend = conf;
                m_pcfg = p;
            end
            if (have) begin
                if (cfg[8:6] == m_major) begin
                    m_minor = cfg[3:0];
                    m_sub   = cfg[5:4];
                end else begin
                    m_active = 1'b1;
                    m_t      = 1;
                    m_tgt    = cfg;
                    m_pwr    = 1'b0;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("major", 16'(major_mode), 16'(m_major));
        chk("minor", 16'(minor_mode), 16'(m_minor));
        chk("sub", 16'(subcarrier_frequency), 16'(m_sub));
        chk("trace", 16'(trace_enable), 16'(m_trace));
        chk("pwr_gate", 16'(pwr_gate), 16'(m_pwr));
        chk("busy", 16'(busy), 16'(m_active));
        chk("overwrite", 16'(cmd_overwrite), 16'(m_ovw));
    endtask

    // Drive one cycle's inputs, clock, update the model and compare.
    task automatic tick(input logic v, input logic [15:0] w);
        cmd_valid = v;
        cmd_word  = w;
        @(posedge ck_1356meg);
        if (nreset) model_edge(v, w);
        else model_reset();
        #1;
        cmd_valid = 1'b0;
        cmd_word  = 16'h0000;
        if (cmd_overwrite === 1'b1) ovw_seen++;
        check_model();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_major"}, 16'(major_mode), 16'd7);
        chk({tag, "_minor"}, 16'(minor_mode), 16'd0);
        chk({tag, "_sub"}, 16'(subcarrier_frequency), 16'd0);
        chk({tag, "_trace"}, 16'(trace_enable), 16'd0);
        chk({tag, "_pwr"}, 16'(pwr_gate), 16'd0);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_ovw"}, 16'(cmd_overwrite), 16'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) tick(1'b0, 16'h0000);
        chk_reset_values("reset");
        nreset = 1'b1;
        tick(1'b0, 16'h0000);

        // Power-up transition OFF -> major 0
        tick(1'b1, confreg(3'd0, 2'd0, 4'd2));
        chk("r34_busy_c1", 16'(busy), 16'd1);
        chk("r34_pwr_c1", 16'(pwr_gate), 16'd0);
        for (int c = 2; c <= 100; c++) begin
            tick(1'b0, 16'h0000);
            if (c == 65) chk("r34_major_c65", 16'(major_mode), 16'd7);
            if (c == 66) chk("r34_major_c66", 16'(major_mode), 16'd0);
            if (c == 97) chk("r34_busy_c97", 16'(busy), 16'd1);
            if (c == 97) chk("r34_pwr_c97", 16'(pwr_gate), 16'd0);
            if (c == 98) chk("r34_pwr_c98", 16'(pwr_gate), 16'd1);
            if (c == 98) chk("r34_busy_c98", 16'(busy), 16'd0);
        end

        // Same-major update is immediate
        tick(1'b1, confreg(3'd0, 2'd1, 4'd5));
        chk("r35_minor", 16'(minor_mode), 16'd5);
        chk("r35_sub", 16'(subcarrier_frequency), 16'd1);
        chk("r35_pwr", 16'(pwr_gate), 16'd1);
        chk("r35_busy", 16'(busy), 16'd0);
        repeat (3) tick(1'b0, 16'h0000);

        // Pending slot overwrite during QUIESCE, then chained transition
        ovw_seen = 0;
        tick(1'b1, confreg(3'd2, 2'd0, 4'd1));
        for (int c = 2; c <= 300; c++) begin
            if (c == 5) tick(1'b1, confreg(3'd2, 2'd2, 4'd3));
            else if (c == 20) tick(1'b1, confreg(3'd3, 2'd1, 4'd4));
            else tick(1'b0, 16'h0000);
            if (c == 20) chk("r36_ovw_pulse", 16'(cmd_overwrite), 16'd1);
            if (c == 98) chk("r36_major_first", 16'(major_mode), 16'd2);
            if (c == 99) chk("r36_busy_second", 16'(busy), 16'd1);
        end
        chk("r36_ovw_count", 16'(ovw_seen), 16'd1);
        chk("r36_major_final", 16'(major_mode), 16'd3);
        chk("r36_minor_final", 16'(minor_mode), 16'd4);

        // Back to major 2, then switch OFF without settle
        tick(1'b1, confreg(3'd2, 2'd0, 4'd0));
        repeat (100) tick(1'b0, 16'h0000);
        tick(1'b1, confreg(3'd7, 2'd0, 4'd0));
        chk("r37_pwr_c1", 16'(pwr_gate), 16'd0);
        for (int c = 2; c <= 80; c++) begin
            tick(1'b0, 16'h0000);
            if (c == 65) chk("r37_major_c65", 16'(major_mode), 16'd2);
            if (c == 66) chk("r37_major_c66", 16'(major_mode), 16'd7);
            if (c == 67) chk("r37_busy_c67", 16'(busy), 16'd0);
            if (c == 67) chk("r37_pwr_c67", 16'(pwr_gate), 16'd0);
        end

        // Trace enable during SETTLE; unknown opcode ignored
        tick(1'b1, confreg(3'd1, 2'd3, 4'd9));
        for (int c = 2; c <= 100; c++) begin
            if (c == 70) tick(1'b1, trace_cmd(1'b1));
            else if (c == 80) tick(1'b1, 16'hF1FF);
            else tick(1'b0, 16'h0000);
            if (c == 70) chk("r38_trace", 16'(trace_enable), 16'd1);
            if (c == 97) chk("r38_pwr_c97", 16'(pwr_gate), 16'd0);
            if (c == 98) chk("r38_pwr_c98", 16'(pwr_gate), 16'd1);
            if (c == 98) chk("r38_major", 16'(major_mode), 16'd1);
        end

        // Reset during QUIESCE with a pending command
        tick(1'b1, confreg(3'd4, 2'd0, 4'd0));
        for (int c = 2; c <= 10; c++) begin
            if (c == 5) tick(1'b1, confreg(3'd6, 2'd0, 4'd0));
            else tick(1'b0, 16'h0000);
        end
        nreset = 1'b0;
        #2;
        chk_reset_values("r39_async");
        model_reset();
        repeat (2) tick(1'b0, 16'h0000);
        nreset = 1'b1;
        repeat (150) tick(1'b0, 16'h0000);
        chk("r39_busy_after", 16'(busy), 16'd0);
        chk("r39_major_after", 16'(major_mode), 16'd7);

        // Randomized command traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                rw   = 16'($urandom);
                kind = int'($urandom_range(0, 4));
                case (kind)
                    0, 1, 2: rw[15:12] = 4'h1;
                    3:       rw[15:12] = 4'h2;
                    default: rw[15:12] = 4'hF;
                endcase
                tick(1'b1, rw);
            end else begin
                tick(1'b0, 16'h0000);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
